// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg
// Shared constants and types for the button event queue.
//   ASCII_PRESS_BASE / ASCII_REL_BASE : first character of the press ('A') and
//                                       release ('a') alphabets
//   REG_STAT / REG_POP                : register addresses of the optional
//                                       wishbone slave (BTN_EVT_WB_EN)
//   evt_byte_t                        : one queued event character
//   encode_evt()                      : button index + level -> event character
package btn_evt_pkg;

    localparam logic [7:0] ASCII_PRESS_BASE = 8'h41;
    localparam logic [7:0] ASCII_REL_BASE   = 8'h61;

    localparam logic [3:0] REG_STAT = 4'd0;
    localparam logic [3:0] REG_POP  = 4'd1;

    typedef logic [7:0] evt_byte_t;

    // A pressed button maps into the upper-case alphabet, a released one into
    // the lower-case alphabet, offset by the button index.
    function automatic evt_byte_t encode_evt(input logic level, input logic [4:0] idx);
        return level ? (ASCII_PRESS_BASE + {3'b000, idx})
                     : (ASCII_REL_BASE   + {3'b000, idx});
    endfunction

endpackage

// File: rtl/btn_evt_queue_if.sv
// btn_evt_queue_if
// Bundles the report input, the event output handshake, the status outputs and,
// when BTN_EVT_WB_EN is defined, the wishbone slave signals.
//   master : report source / event consumer (drives rpt_*, out_ack, wb requests)
//   slave  : btn_evt_queue (drives out_*, drop_cnt, busy, wb responses)
interface btn_evt_queue_if #(
    parameter int N_BTN = 16
);
    logic [N_BTN-1:0] rpt_state;
    logic [N_BTN-1:0] rpt_change;
    logic             rpt_stb;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ack;
    logic [7:0]       drop_cnt;
    logic             busy;
`ifdef BTN_EVT_WB_EN
    logic [3:0]       wb_addr;
    logic [31:0]      wb_rdata;
    logic [31:0]      wb_wdata;
    logic             wb_we;
    logic             wb_cyc;
    logic             wb_ack;

    modport master (
        output rpt_state, rpt_change, rpt_stb, out_ack,
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  out_data, out_valid, drop_cnt, busy,
        input  wb_rdata, wb_ack
    );
    modport slave (
        input  rpt_state, rpt_change, rpt_stb, out_ack,
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output out_data, out_valid, drop_cnt, busy,
        output wb_rdata, wb_ack
    );
`else
    modport master (
        output rpt_state, rpt_change, rpt_stb, out_ack,
        input  out_data, out_valid, drop_cnt, busy
    );
    modport slave (
        input  rpt_state, rpt_change, rpt_stb, out_ack,
        output out_data, out_valid, drop_cnt, busy
    );
`endif
endinterface

// File: rtl/btn_evt_fifo.sv
// btn_evt_fifo
// Synchronous 8-bit FIFO holding queued event characters.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data (accepted when not full, or when a
//                   pop happens in the same cycle)
//   pop_i         : remove head (ignored when empty)
//   data_o        : current head byte
//   full_o/empty_o/level_o : occupancy flags and entry count
module btn_evt_fifo
    import btn_evt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  evt_byte_t                data_i,
    input  logic                     pop_i,
    output evt_byte_t                data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    evt_byte_t   mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level_o = wr_q - rd_q;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign wr_d    = wr_q + (AW+1)'(do_push);
    assign rd_d    = rd_q + (AW+1)'(do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/btn_evt_queue.sv
// btn_evt_queue
// Converts button-state reports into a queue of per-button ASCII events
// ('A'+i on press, 'a'+i on release) for the debug UART.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : btn_evt_queue_if slave modport
//                rpt_state/rpt_change/rpt_stb : incoming report
//                out_data/out_valid/out_ack   : event stream to the consumer
//                drop_cnt                     : saturating lost-event count
//                busy                         : change bits still waiting to be scanned
// Optional: define BTN_EVT_WB_EN to add a wishbone slave (status read,
// drop counter clear, head pop).
module btn_evt_queue
    import btn_evt_pkg::*;
#(
    parameter int N_BTN      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_evt_queue_if.slave bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] lat_q, lat_d;
    logic [7:0]       drop_q, drop_d;

    logic             scan_vld;
    logic [4:0]       scan_idx;
    logic             scan_lvl;
    logic [N_BTN-1:0] scan_clr;
    evt_byte_t        scan_byte;

    logic [N_BTN-1:0] rechg;
    logic [5:0]       rechg_cnt;
    logic [9:0]       drop_sum;
    logic             full_drop;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    evt_byte_t        fifo_head;
    logic [LW-1:0]    fifo_level;

    logic             wb_pop;
    logic             wb_clr;

    // Lowest-set-bit priority encoder: the descending loop lets the lowest
    // pending index overwrite any higher one.
    always_comb begin
        scan_vld = 1'b0;
        scan_idx = '0;
        scan_lvl = 1'b0;
        scan_clr = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                scan_vld    = 1'b1;
                scan_idx    = 5'(i);
                scan_lvl    = lat_q[i];
                scan_clr    = '0;
                scan_clr[i] = 1'b1;
            end
        end
    end

    assign scan_byte = encode_evt(scan_lvl, scan_idx);
    assign fifo_pop  = ~fifo_empty & (bus.out_ack | wb_pop);
    assign fifo_push = scan_vld & (~fifo_full | fifo_pop);
    assign full_drop = scan_vld & ~fifo_push;

    // A change on a bit that is still pending (and not being emitted this very
    // cycle) merges into the existing event, so the earlier transition is lost.
    assign rechg = bus.rpt_stb ? (bus.rpt_change & pending_q & ~scan_clr) : '0;

    always_comb begin
        rechg_cnt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rechg_cnt = rechg_cnt + 6'(rechg[i]);
        end
    end

    // Next state: the capture is applied after the scanner clear so a new change
    // on the bit being emitted keeps it pending; the drop counter saturates.
    always_comb begin
        pending_d = pending_q & ~scan_clr;
        lat_d     = lat_q;
        if (bus.rpt_stb) begin
            pending_d = pending_d | bus.rpt_change;
            lat_d     = (lat_q & ~bus.rpt_change) | (bus.rpt_state & bus.rpt_change);
        end
        drop_sum = 10'(drop_q) + 10'(rechg_cnt) + 10'(full_drop);
        drop_d   = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
        if (wb_clr) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            lat_q     <= '0;
            drop_q    <= '0;
        end else begin
            pending_q <= pending_d;
            lat_q     <= lat_d;
            drop_q    <= drop_d;
        end
    end

    btn_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .data_i  (scan_byte),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_head;
    assign bus.drop_cnt  = drop_q;
    assign bus.busy      = |pending_q;

`ifdef BTN_EVT_WB_EN
    logic        wb_ack_q;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic        wb_req;
    logic [8:0]  level9;
    logic        wb_wdata_unused;

    // A request is taken on the first cycle of cyc; ack follows one cycle later
    // as a single pulse, and the pop/clear side effects happen on that same edge.
    assign wb_req          = bus.wb_cyc & ~wb_ack_q;
    assign wb_pop          = wb_req & ~bus.wb_we & (bus.wb_addr == REG_POP);
    assign wb_clr          = wb_req &  bus.wb_we & (bus.wb_addr == REG_STAT);
    assign level9          = 9'(fifo_level);
    assign wb_wdata_unused = ^bus.wb_wdata;

    always_comb begin
        wb_rdata_d = '0;
        if (wb_req && !bus.wb_we) begin
            if (bus.wb_addr == REG_STAT) begin
                wb_rdata_d = {fifo_empty, 7'b0, level9[7:0], drop_q, 8'h00};
            end else if (bus.wb_addr == REG_POP) begin
                wb_rdata_d = {23'b0, ~fifo_empty, fifo_head};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_q   <= 1'b0;
            wb_rdata_q <= '0;
        end else begin
            wb_ack_q   <= wb_req;
            wb_rdata_q <= wb_rdata_d;
        end
    end

    assign bus.wb_ack   = wb_ack_q;
    assign bus.wb_rdata = wb_rdata_q;
`else
    logic level_unused;

    assign wb_pop       = 1'b0;
    assign wb_clr       = 1'b0;
    assign level_unused = ^fifo_level;
`endif

endmodule

// File: tb/tb_btn_evt_queue.sv
// tb_btn_evt_queue
// Self-checking bench for btn_evt_queue (N_BTN=16, FIFO_DEPTH=16) using a
// queue-based behavioural model. Define BTN_EVT_WB_EN to also exercise the
// wishbone slave.
module tb_btn_evt_queue;
    import btn_evt_pkg::*;

    localparam int NB    = 16;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] mq[$];
    bit         mPend[NB];
    bit         mLvl[NB];
    int         mDrop;

    btn_evt_queue_if #(.N_BTN(NB)) bus();

    btn_evt_queue #(.N_BTN(NB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global guard so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] encodeRef(input bit lvl, input int i);
        return lvl ? 8'(65 + i) : 8'(97 + i);
    endfunction

    function automatic bit modelBusy();
        bit b = 1'b0;
        for (int i = 0; i < NB; i++) b |= mPend[i];
        return b;
    endfunction

    function automatic void modelReset();
        mq.delete();
        for (int i = 0; i < NB; i++) begin
            mPend[i] = 1'b0;
            mLvl[i]  = 1'b0;
        end
        mDrop = 0;
    endfunction

    // Model of one clock edge: pop, then emit the lowest pending button into the
    // queue (or count it lost when full), then fold in the new report.
    function automatic void modelStep(input logic stb, input logic [15:0] chg,
                                      input logic [15:0] st, input logic ack);
        int scanIdx = -1;
        if (ack && mq.size() > 0) void'(mq.pop_front());
        for (int i = 0; i < NB; i++) begin
            if (mPend[i]) begin
                scanIdx = i;
                break;
            end
        end
        if (scanIdx >= 0) begin
            if (mq.size() < DEPTH) mq.push_back(encodeRef(mLvl[scanIdx], scanIdx));
            else mDrop++;
            mPend[scanIdx] = 1'b0;
        end
        if (stb) begin
            for (int i = 0; i < NB; i++) begin
                if (chg[i]) begin
                    if (mPend[i]) mDrop++;
                    mPend[i] = 1'b1;
                    mLvl[i]  = st[i];
                end
            end
        end
        if (mDrop > 255) mDrop = 255;
    endfunction

    // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
    task automatic applyStimulus(input logic stb, input logic [15:0] chg,
                                 input logic [15:0] st, input logic ack);
        bus.rpt_stb    = stb;
        bus.rpt_change = chg;
        bus.rpt_state  = st;
        bus.out_ack    = ack;
        modelStep(stb, chg, st, ack);
        @(posedge clk);
        #1;
        bus.rpt_stb    = 1'b0;
        bus.rpt_change = '0;
        bus.out_ack    = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.drop_cnt !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_state: valid=%b busy=%b drop=%h, required 0/0/00",
                     bus.out_valid, bus.busy, bus.drop_cnt);
        end
        doReset();
        applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: valid=%b busy=%b, required 0/0",
                     bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_single();
        int b = $urandom_range(0, NB - 1);
        logic [15:0] m = 16'(1) << b;
        doReset();
        applyStimulus(1'b1, m, m, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_lat1: valid=%b busy=%b, required 0/1", bus.out_valid, bus.busy);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h41 + b)) begin
            errors++;
            $display("[TB] FAIL single_event: valid=%b data=%h, required 1/%h",
                     bus.out_valid, bus.out_data, 8'(8'h41 + b));
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ack: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_multi_bit();
        logic       expBusy[3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] expData[3] = '{8'h00, 8'h61, 8'h43};
        doReset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) applyStimulus(1'b1, 16'h0005, 16'h0004, 1'b0);
            else        applyStimulus(1'b0, '0, '0, 1'b1);
            checks++;
            if (bus.busy !== expBusy[c]) begin
                errors++;
                $display("[TB] FAIL multi_busy[%0d]: busy=%b, required %b", c, bus.busy, expBusy[c]);
            end
            if (c > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== expData[c]) begin
                    errors++;
                    $display("[TB] FAIL multi_data[%0d]: valid=%b data=%h, required 1/%h",
                             c, bus.out_valid, bus.out_data, expData[c]);
                end
            end
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL multi_empty: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        doReset();
        for (int r = 0; r < 20; r++) begin
            int b = $urandom_range(0, NB - 1);
            logic [15:0] m  = 16'(1) << b;
            logic [15:0] st = 16'($urandom);
            if (r < DEPTH) exp.push_back(encodeRef(st[b], b));
            applyStimulus(1'b1, m, st, 1'b0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.drop_cnt !== 8'd4 || mDrop != 4) begin
            errors++;
            $display("[TB] FAIL overflow_drop: drop=%0d, required 4", bus.drop_cnt);
        end
        for (int j = 0; j < DEPTH; j++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp[j]) begin
                errors++;
                $display("[TB] FAIL overflow_drain[%0d]: valid=%b data=%h, required 1/%h",
                         j, bus.out_valid, bus.out_data, exp[j]);
            end
            applyStimulus(1'b0, '0, '0, 1'b1);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_empty: valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_rechange();
        int n = 0;
        logic [7:0] last = 8'h00;
        doReset();
        applyStimulus(1'b1, 16'hFFFF, 16'($urandom), 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0000, 1'b0);
        repeat (15) applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.drop_cnt !== 8'd1 || bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rechange_drop: drop=%0d busy=%b, required 1/0", bus.drop_cnt, bus.busy);
        end
        for (int j = 0; j < 20 && bus.out_valid === 1'b1; j++) begin
            checks++;
            if (bus.out_data !== mq[0]) begin
                errors++;
                $display("[TB] FAIL rechange_order[%0d]: data=%h, required %h", j, bus.out_data, mq[0]);
            end
            last = bus.out_data;
            n++;
            applyStimulus(1'b0, '0, '0, 1'b1);
        end
        checks++;
        if (n != 16 || last !== 8'h70) begin
            errors++;
            $display("[TB] FAIL rechange_count: events=%0d last=%h, required 16/70", n, last);
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        applyStimulus(1'b1, 16'hFFFF, 16'($urandom), 1'b0);
        applyStimulus(1'b1, 16'h8000, 16'h0000, 1'b0);
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1 || bus.drop_cnt !== 8'd1 || mq.size() != 5) begin
            errors++;
            $display("[TB] FAIL midreset_setup: busy=%b valid=%b drop=%0d, required 1/1/1",
                     bus.busy, bus.out_valid, bus.drop_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset_async: valid=%b busy=%b drop=%0d, required 0/0/0",
                     bus.out_valid, bus.busy, bus.drop_cnt);
        end
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet[%0d]: valid=%b busy=%b, required 0/0",
                         c, bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            logic        stb = ($urandom_range(0, 2) == 0);
            logic [15:0] chg = 16'($urandom) & 16'($urandom) & 16'($urandom);
            logic        ack = ($urandom_range(0, 3) != 0) && (c < 200 || c > 260);
            applyStimulus(stb, chg, 16'($urandom), ack);
            checks++;
            if (bus.out_valid !== (mq.size() != 0) || bus.busy !== modelBusy()
                || bus.drop_cnt !== 8'(mDrop)) begin
                errors++;
                $display("[TB] FAIL random_status[%0d]: valid=%b busy=%b drop=%0d, required %b/%b/%0d",
                         c, bus.out_valid, bus.busy, bus.drop_cnt, mq.size() != 0, modelBusy(), mDrop);
            end
            if (mq.size() != 0) begin
                checks++;
                if (bus.out_data !== mq[0]) begin
                    errors++;
                    $display("[TB] FAIL random_data[%0d]: data=%h, required %h", c, bus.out_data, mq[0]);
                end
            end
        end
    endtask

`ifdef BTN_EVT_WB_EN
    // One wishbone access, optionally with out_ack asserted in the same cycle.
    task automatic wbAccess(input logic we, input logic [3:0] addr, input logic ack,
                            output logic gotAck, output logic [31:0] gotData);
        bus.wb_cyc   = 1'b1;
        bus.wb_we    = we;
        bus.wb_addr  = addr;
        bus.wb_wdata = 32'($urandom);
        bus.out_ack  = ack;
        @(posedge clk);
        #1;
        gotAck      = bus.wb_ack;
        gotData     = bus.wb_rdata;
        bus.wb_cyc  = 1'b0;
        bus.wb_we   = 1'b0;
        bus.out_ack = 1'b0;
    endtask

    task automatic test_wishbone();
        logic        a;
        logic [31:0] d;
        doReset();
        applyStimulus(1'b1, 16'h0006, 16'h0006, 1'b0);
        applyStimulus(1'b1, 16'h0004, 16'h0004, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);
        wbAccess(1'b0, REG_STAT, 1'b0, a, d);
        checks++;
        if (a !== 1'b1 || d !== 32'h0002_0100) begin
            errors++;
            $display("[TB] FAIL wb_status: ack=%b rdata=%h, required 1/00020100", a, d);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        checks++;
        if (bus.wb_ack !== 1'b0 || bus.wb_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wb_idle: ack=%b rdata=%h, required 0/00000000", bus.wb_ack, bus.wb_rdata);
        end
        wbAccess(1'b0, REG_POP, 1'b0, a, d);
        void'(mq.pop_front());
        checks++;
        if (a !== 1'b1 || d !== 32'h0000_0142 || bus.out_data !== 8'h43) begin
            errors++;
            $display("[TB] FAIL wb_pop: ack=%b rdata=%h head=%h, required 1/00000142/43", a, d, bus.out_data);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        wbAccess(1'b1, REG_STAT, 1'b0, a, d);
        mDrop = 0;
        checks++;
        if (bus.drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wb_clear: drop=%0d, required 0", bus.drop_cnt);
        end
        applyStimulus(1'b1, 16'h0018, 16'h0018, 1'b0);
        repeat (3) applyStimulus(1'b0, '0, '0, 1'b0);
        wbAccess(1'b0, REG_POP, 1'b1, a, d);
        void'(mq.pop_front());
        checks++;
        if (d !== 32'h0000_0143 || bus.out_data !== 8'h44 || mq[0] !== 8'h44) begin
            errors++;
            $display("[TB] FAIL wb_dual_pop: rdata=%h head=%h, required 00000143/44", d, bus.out_data);
        end
    endtask
`endif

    // Sequence of scenarios followed by the summary line.
    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b1;
        bus.rpt_stb    = 1'b0;
        bus.rpt_change = '0;
        bus.rpt_state  = '0;
        bus.out_ack    = 1'b0;
`ifdef BTN_EVT_WB_EN
        bus.wb_cyc     = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_addr    = '0;
        bus.wb_wdata   = '0;
`endif
        modelReset();
        test_reset();
        test_single();
        test_multi_bit();
        test_overflow();
        test_rechange();
        test_reset_mid();
        test_random();
`ifdef BTN_EVT_WB_EN
        test_wishbone();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
